instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Multicycle-CPU fetch stage driving the instruction register's load side. It owns the program counter, runs a request/ready read handshake to instruction memory, and presents the fetched word on `instr_out` with a one-cycle `ir_write` strobe. The control FSM starts each fetch with `fetch_start` and redirects the PC with `pc_load`.

## Interface
- `ADDR_W`, 32: PC and memory address width.
- `RESET_PC`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `TIMEOUT_CYCLES`, 16: watchdog limit, used only with `IFU_TIMEOUT_EN`; legal range 2..255.
- `clk`  in  1  clock.
- `reset`  in  1  reset: synchronous, active-high. Clock is `clk`.
- `fetch_start`  in  1  request one fetch at the current PC.
- `pc_load`  in  1  load `pc_target` into the PC.
- `pc_target`  in  ADDR_W  branch/jump target.
- `mem_addr`  out  ADDR_W  instruction memory address (the current PC).
- `mem_rd`  out  1  read request, held high until accepted.
- `mem_rdata`  in  32  read data, valid when `mem_ready` is high.
- `mem_ready`  in  1  read-accept and data-valid strobe.
- `instr_out`  out  32  fetched instruction; feeds the IR's `Instruc_in`.
- `ir_write`  out  1  one-cycle strobe; feeds the IR's `Irwrite`.
- `pc`  out  ADDR_W  current PC.
- `pc_plus4`  out  ADDR_W  `pc + 4`, combinational.
- `busy`  out  1  high in any state other than IDLE.
- `fetch_fault`  out  1  one-cycle timeout pulse; tied 0 without `IFU_TIMEOUT_EN`.

## Operation
- FSM states and transitions:
  - IDLE → FETCH on `fetch_start`, unless `pc_load` is also high.
  - FETCH → WRITE on `mem_ready`.
  - WRITE → IDLE unconditionally.
- IDLE:
  - `mem_rd`=0.
  - `pc_load` loads `{pc_target[ADDR_W-1:2],2'b00}`.
  - `pc_load` together with `fetch_start`: the load wins and `fetch_start` is dropped. Control must reissue it.
  - `mem_ready` is ignored.
- FETCH:
  - `mem_rd`=1; `mem_addr`=`pc`, stable for the whole state.
  - `mem_rdata` is captured into `instr_out` on the edge where `mem_ready`=1.
  - `pc_load` and `fetch_start` are ignored.
- WRITE:
  - `ir_write`=1 for exactly this cycle; `instr_out` is valid.
  - PC ← `pc + 4`, modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0.
  - `pc_load` and `fetch_start` are ignored.
- `instr_out` holds its last captured value until the next capture.
- Reset values: `pc`=RESET_PC, `instr_out`=0, `mem_rd`=0, `ir_write`=0, `busy`=0, `fetch_fault`=0, state IDLE.
- Reset mid-fetch abandons the access. A `mem_ready` arriving after reset is ignored.

## Timing
- `fetch_start` is sampled high at edge 0. `mem_rd` is high from cycle 1.
- `mem_ready` arrives in cycle k≥1 and is sampled at edge k. `ir_write` and the valid `instr_out` appear in cycle k+1.
- The new PC is visible in cycle k+2.
- Minimum latency from `fetch_start` to `ir_write` is 2 cycles (zero-wait memory).
- Back-to-back fetches: `fetch_start` is accepted in the cycle after WRITE. One fetch therefore takes 3 cycles minimum.
- `pc_load` in IDLE at edge n: the new `pc` is visible in cycle n+1.
- All outputs are registered except `pc_plus4` and `busy`, which decode directly from registers.

## Configuration
- `IFU_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH and increments each FETCH cycle without `mem_ready`.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE and `mem_rd` drops.
  - `fetch_fault` pulses 1 cycle. There is no `ir_write`, and both PC and `instr_out` stay unchanged.
  - `mem_ready` in the same cycle as the limit: the fetch completes normally and there is no fault.
- `IFU_TIMEOUT_EN` undefined: FETCH waits indefinitely, `fetch_fault`=0, and no counter logic exists.

## Structure
- Package `ifu_pkg` holds:
  - the state enum (IDLE, FETCH, WRITE);
  - `IFU_PC_INCR`=4;
  - `IFU_RESET_PC` default.
- Sub-module `ifu_watchdog` (wait counter plus limit compare) is instantiated only under `IFU_TIMEOUT_EN`.

## Test plan
- Zero-wait fetch: reset, then `fetch_start` at PC 0, with `mem_ready` in the first FETCH cycle and `mem_rdata`=32'h8C22_0004. Expected: `ir_write` 2 cycles after start, `instr_out`=32'h8C22_0004, then `pc`=4.
- Wait states: `mem_ready` arrives 3 cycles after `mem_rd` rises. Expected: `mem_rd` and `mem_addr` stay stable throughout, `ir_write` appears exactly once, and early `mem_rdata` garbage is not captured.
- Redirect: in IDLE, `pc_load` with `pc_target`=32'h0000_0103. Expected: `pc`=32'h0000_0100. With `pc_load` and `fetch_start` together: no fetch and `busy` stays 0. A `pc_load` during FETCH has no effect.
- Wrap and reset: PC=32'hFFFF_FFFC, then fetch. Expected: `pc`=0. Assert reset during FETCH. Expected: `mem_rd`=0 next cycle, `pc`=RESET_PC, and a later `mem_ready` produces no `ir_write`.
- Timeout (macro on, TIMEOUT_CYCLES=4): `mem_ready` is never asserted. Expected: `fetch_fault` pulses after 4 FETCH cycles, `pc` is unchanged, and there is no `ir_write`. With the macro off, the same stimulus leaves the FSM in FETCH.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg
// Shared definitions for the instruction fetch unit:
//   ifu_state_e   - fetch FSM states
//   IFU_PC_INCR   - byte increment applied to the PC after each fetch
//   IFU_RESET_PC  - default PC value after reset (word aligned)
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } ifu_state_e;

    localparam int unsigned IFU_PC_INCR  = 4;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if
// Request/ready read bus between the fetch unit and instruction memory.
//   mem_addr  - word address of the requested instruction (fetch unit drives)
//   mem_rd    - read request, held until accepted (fetch unit drives)
//   mem_rdata - read data, valid with mem_ready (memory drives)
//   mem_ready - accept and data-valid strobe (memory drives)
// Modports: master = fetch unit side, slave = memory side.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/ifu_watchdog.sv
// ifu_watchdog
// Counts FETCH cycles that pass without mem_ready and flags the cycle in
// which the limit is reached. Only compiled when IFU_TIMEOUT_EN is defined;
// without the macro this file is empty and no counter logic exists.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   in_fetch   - fetch FSM is in FETCH this cycle
//   ready      - memory accepted the read this cycle
//   expired    - this FETCH cycle is the LIMIT-th without ready (combinational)
`ifdef IFU_TIMEOUT_EN
module ifu_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_fetch,
    input  logic ready,
    output logic expired
);
    logic [7:0] wait_cnt;

    // Held at zero outside FETCH, so it is already clear on FETCH entry.
    always_ff @(posedge clk) begin
        if (reset || !in_fetch) begin
            wait_cnt <= 8'd0;
        end else if (!ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // wait_cnt counts completed idle FETCH cycles, so the LIMIT-th one is
    // the cycle in which the count still reads LIMIT-1. A ready in that
    // same cycle wins and completes the fetch normally.
    assign expired = in_fetch && !ready && (wait_cnt == 8'(LIMIT - 1));
endmodule
`endif

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Multicycle-CPU fetch stage: owns the PC, reads instruction memory over a
// request/ready handshake and loads the fetched word into the IR with a
// one-cycle ir_write strobe.
// Optional feature: define IFU_TIMEOUT_EN to enable the FETCH watchdog
// (abort after TIMEOUT_CYCLES idle FETCH cycles with a fetch_fault pulse).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   fetch_start - start one fetch at the current PC (IDLE only)
//   pc_load     - load word-aligned pc_target into the PC (IDLE only; wins
//                 over fetch_start)
//   pc_target   - branch/jump target
//   mem         - instruction memory bus (master side)
//   instr_out   - last fetched instruction (IR Instruc_in)
//   ir_write    - one-cycle IR load strobe (IR Irwrite)
//   pc          - current PC; pc_plus4 - pc + 4 (combinational)
//   busy        - FSM not in IDLE
//   fetch_fault - one-cycle timeout pulse (0 without IFU_TIMEOUT_EN)
//
// state | meaning
// IDLE  | waiting for fetch_start; accepts pc_load
// FETCH | mem_rd high at mem_addr = pc until mem_ready
// WRITE | ir_write high, instr_out valid, pc advances by 4
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(IFU_RESET_PC),
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_start,
    input  logic                     pc_load,
    input  logic [ADDR_W-1:0]        pc_target,
    instruction_fetch_unit_if.master mem,
    output logic [31:0]              instr_out,
    output logic                     ir_write,
    output logic [ADDR_W-1:0]        pc,
    output logic [ADDR_W-1:0]        pc_plus4,
    output logic                     busy,
    output logic                     fetch_fault
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("instruction_fetch_unit: TIMEOUT_CYCLES must be in 2..255");
    end

    ifu_state_e state;
    ifu_state_e state_next;

    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       instr_q;
    logic              mem_rd_q;
    logic              ir_write_q;
    logic              fault_q;
    logic              in_fetch;
    logic              timeout;
    logic              unused_target_lsbs;

    // Targets are forced to a word boundary, so the low bits never matter.
    assign unused_target_lsbs = ^pc_target[1:0];

    assign in_fetch = (state == FETCH);

`ifdef IFU_TIMEOUT_EN
    ifu_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .in_fetch (in_fetch),
        .ready    (mem.mem_ready),
        .expired  (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // A simultaneous pc_load wins; the fetch request is dropped.
                if (fetch_start && !pc_load) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (mem.mem_ready) begin
                    state_next = WRITE;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up exactly
    // with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= {RESET_PC[ADDR_W-1:2], 2'b00};
            instr_q    <= 32'd0;
            mem_rd_q   <= 1'b0;
            ir_write_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            mem_rd_q   <= (state_next == FETCH);
            ir_write_q <= (state_next == WRITE);
            fault_q    <= in_fetch && !mem.mem_ready && timeout;

            if (in_fetch && mem.mem_ready) begin
                instr_q <= mem.mem_rdata;
            end

            if (state == IDLE && pc_load) begin
                pc_q <= {pc_target[ADDR_W-1:2], 2'b00};
            end else if (state == WRITE) begin
                pc_q <= pc_q + ADDR_W'(IFU_PC_INCR);
            end
        end
    end

    assign mem.mem_addr = pc_q;
    assign mem.mem_rd   = mem_rd_q;
    assign instr_out    = instr_q;
    assign ir_write     = ir_write_q;
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + ADDR_W'(IFU_PC_INCR);
    assign busy         = (state != IDLE);
    assign fetch_fault  = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Self-checking bench for instruction_fetch_unit. Expected values come from
// a transaction-level model (expected PC and last instruction) updated per
// redirect or fetch, plus a table of fixed redirect/fetch vectors with
// hand-computed PCs and a few hand-written corner sequences.
module tb_instruction_fetch_unit;

    localparam int          ADDR_W = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [31:0] instr_out;
    logic        ir_write;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        busy;
    logic        fetch_fault;

    instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) mem_bus ();

    instruction_fetch_unit #(
        .ADDR_W         (ADDR_W),
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .mem         (mem_bus),
        .instr_out   (instr_out),
        .ir_write    (ir_write),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .busy        (busy),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    typedef struct {
        logic [31:0] target;
        logic        with_start;
        int          waits;
        logic [31:0] data;
        logic [31:0] exp_load_pc;
        logic [31:0] exp_next_pc;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_start       = 1'b0;
        pc_load           = 1'b0;
        pc_target         = 32'd0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = $urandom;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_pc"},       pc,          exp_pc);
        chk({tag, "_pc_plus4"}, pc_plus4,    exp_pc + 32'd4);
        chk({tag, "_busy"},     busy,        1'b0);
        chk({tag, "_mem_rd"},   mem_bus.mem_rd, 1'b0);
        chk({tag, "_ir_write"}, ir_write,    1'b0);
        chk({tag, "_fault"},    fetch_fault, 1'b0);
        chk({tag, "_instr"},    instr_out,   exp_instr);
    endtask

    // Redirect from IDLE; mem_ready noise must be ignored, and a concurrent
    // fetch_start must be dropped (checked one cycle later as well).
    task automatic do_load(input logic [31:0] target, input logic with_start);
        pc_load           = 1'b1;
        pc_target         = target;
        fetch_start       = with_start;
        mem_bus.mem_ready = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata = $urandom;
        tick();
        idle_inputs();
        exp_pc = {target[31:2], 2'b00};
        check_idle("load");
        tick();
        check_idle("load_hold");
    endtask

    // One fetch with `waits` FETCH cycles before mem_ready. pc_load and
    // fetch_start are randomised during FETCH and WRITE to show they are ignored.
    task automatic do_fetch(input int waits, input logic [31:0] data);
        logic [31:0] addr0;
        addr0       = exp_pc;
        fetch_start = 1'b1;
        pc_load     = 1'b0;
        tick();
        for (int i = 0; i <= waits; i++) begin
            chk("fetch_mem_rd",   mem_bus.mem_rd,   1'b1);
            chk("fetch_mem_addr", mem_bus.mem_addr, addr0);
            chk("fetch_busy",     busy,             1'b1);
            chk("fetch_ir_write", ir_write,         1'b0);
            chk("fetch_fault",    fetch_fault,      1'b0);
            chk("fetch_pc",       pc,               addr0);
            mem_bus.mem_ready = (i == waits);
            mem_bus.mem_rdata = (i == waits) ? data : $urandom;
            pc_load           = 1'($urandom_range(0, 1));
            pc_target         = $urandom;
            fetch_start       = 1'($urandom_range(0, 1));
            tick();
        end
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = $urandom;
        chk("write_ir_write", ir_write,       1'b1);
        chk("write_instr",    instr_out,      data);
        chk("write_pc",       pc,             addr0);
        chk("write_mem_rd",   mem_bus.mem_rd, 1'b0);
        chk("write_busy",     busy,           1'b1);
        pc_load     = 1'($urandom_range(0, 1));
        pc_target   = $urandom;
        fetch_start = 1'($urandom_range(0, 1));
        tick();
        idle_inputs();
        exp_pc    = addr0 + 32'd4;
        exp_instr = data;
        check_idle("post_fetch");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{32'h0000_0103, 1'b0, 0, 32'h1111_0001, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'h0000_0200, 1'b1, 2, 32'h2222_0002, 32'h0000_0200, 32'h0000_0204};
        vecs[2] = '{32'hFFFF_FFFC, 1'b0, 1, 32'h3333_0003, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 3, 32'h4444_0004, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{32'h8000_0002, 1'b0, 0, 32'h5555_0005, 32'h8000_0000, 32'h8000_0004};
        vecs[5] = '{32'h0000_0010, 1'b0, 3, 32'h6666_0006, 32'h0000_0010, 32'h0000_0014};

        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        exp_pc    = RST_PC;
        exp_instr = 32'd0;
        check_idle("reset");
        reset = 1'b0;

        // Zero-wait fetch at PC 0: ir_write two cycles after fetch_start.
        do_fetch(0, 32'h8C22_0004);
        chk("zero_wait_pc", pc, 32'h0000_0004);

        // Back-to-back: next fetch accepted right after WRITE.
        do_fetch(1, 32'hA5A5_0001);

        for (int v = 0; v < 6; v++) begin
            do_load(vecs[v].target, vecs[v].with_start);
            chk("tbl_load_pc", pc, vecs[v].exp_load_pc);
            do_fetch(vecs[v].waits, vecs[v].data);
            chk("tbl_next_pc", pc, vecs[v].exp_next_pc);
        end

        // Reset in the middle of FETCH abandons the access.
        do_load(32'h0000_0400, 1'b0);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("rst_mid_mem_rd_before", mem_bus.mem_rd, 1'b1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        exp_pc    = RST_PC;
        exp_instr = 32'd0;
        check_idle("rst_mid");
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_bus.mem_ready = 1'b0;
        check_idle("rst_late_ready");
        tick();
        check_idle("rst_late_ready2");

        // Memory never answers.
        do_load(32'h0000_0300, 1'b0);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
`ifdef IFU_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            chk("to_mem_rd", mem_bus.mem_rd, 1'b1);
            chk("to_fault_early", fetch_fault, 1'b0);
            chk("to_addr", mem_bus.mem_addr, exp_pc);
            pc_load   = 1'b1;
            pc_target = $urandom;
            tick();
        end
        pc_load = 1'b0;
        chk("to_fault", fetch_fault, 1'b1);
        chk("to_mem_rd_drop", mem_bus.mem_rd, 1'b0);
        chk("to_busy", busy, 1'b0);
        chk("to_ir_write", ir_write, 1'b0);
        chk("to_pc", pc, exp_pc);
        chk("to_instr", instr_out, exp_instr);
        tick();
        check_idle("to_after");
`else
        for (int i = 0; i < TO + 2; i++) begin
            chk("noto_mem_rd", mem_bus.mem_rd, 1'b1);
            chk("noto_busy", busy, 1'b1);
            chk("noto_fault", fetch_fault, 1'b0);
            chk("noto_ir_write", ir_write, 1'b0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        exp_pc    = RST_PC;
        exp_instr = 32'd0;
        check_idle("noto_reset");
`endif

        // Randomised redirects and fetches against the transaction model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_load($urandom, 1'($urandom_range(0, 1)));
            end else begin
                do_fetch(int'($urandom_range(0, 3)), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
